// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_pkg
//  Brief    : Shared types and line-level constants for the UART receive path.
//  Revision : 1.0  initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        STOP    = 3'd3,
        WAIT_HI = 3'd4
    } rx_state_t;

    localparam logic UART_IDLE_LVL   = 1'b1;
    localparam logic UART_START_LVL  = 1'b0;
    localparam int   UART_FRAME_BITS = 10;

    // 2-of-3 vote used when the majority sampler is built in
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_rx_sync.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_sync
//  Brief    : Two-flop synchronizer for the asynchronous serial line. Both
//             stages reset to the idle level so no false start is seen.
//  Revision : 1.0  initial release
// ============================================================================
module uart_rx_sync
    import uart_pkg::*;
(
    input  logic sys_clock,
    input  logic reset,
    input  logic rxd,
    output logic rxd_s
);

    logic meta;

    // Resolve metastability over two stages before any decision uses the line
    always_ff @(posedge sys_clock or posedge reset) begin
        if (reset) begin
            meta  <= UART_IDLE_LVL;
            rxd_s <= UART_IDLE_LVL;
        end else begin
            meta  <= rxd;
            rxd_s <= meta;
        end
    end

endmodule : uart_rx_sync
`default_nettype wire

// File: rtl/uart_rx_frame.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_frame
//  Brief    : Oversampling UART receiver. Recovers start/8-data/stop frames,
//             holds one byte behind a valid/ready handshake and pulses
//             framing and overrun errors.
//             Build option UART_RX_MAJORITY_EN: each bit decision is a 2-of-3
//             vote around the mid-bit point, taken one cycle later.
//  Revision : 1.0  initial release
// ============================================================================
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8
) (
    input  logic                 sys_clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 frame_err,
    output logic                 overrun_err,
    output logic                 busy
);

    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

`ifdef UART_RX_MAJORITY_EN
    // Vote needs the cycle after mid-bit; shifting the start decision by one
    // keeps every later decision (at BIT_LAST) aligned one cycle past mid-bit.
    localparam logic [CNT_W-1:0] START_DECIDE = CNT_W'(CLKS_PER_BIT / 2);
`else
    localparam logic [CNT_W-1:0] START_DECIDE = CNT_W'(CLKS_PER_BIT / 2 - 1);
`endif

    rx_state_t            state;
    logic [CNT_W-1:0]     baud_cnt;
    logic [IDX_W-1:0]     bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 rxd_s;
    logic                 sample_bit;

    uart_rx_sync u_sync (
        .sys_clock (sys_clock),
        .reset     (reset),
        .rxd       (rxd),
        .rxd_s     (rxd_s)
    );

`ifdef UART_RX_MAJORITY_EN
    logic hist_1;
    logic hist_2;

    // Two-deep history of the synchronized line for the 3-point vote
    always_ff @(posedge sys_clock or posedge reset) begin
        if (reset) begin
            hist_1 <= UART_IDLE_LVL;
            hist_2 <= UART_IDLE_LVL;
        end else begin
            hist_1 <= rxd_s;
            hist_2 <= hist_1;
        end
    end

    assign sample_bit = maj3(hist_2, hist_1, rxd_s);
`else
    assign sample_bit = rxd_s;
`endif

    assign busy = (state != IDLE);

    // Frame FSM, bit timing, shift register, holding register and error pulses
    always_ff @(posedge sys_clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            baud_cnt    <= '0;
            bit_idx     <= '0;
            shreg       <= '0;
            data_out    <= '0;
            data_valid  <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;

            // Consumer handshake works regardless of receiver state or enable;
            // a commit later in this block takes priority over the clear.
            if (data_valid && data_ready) begin
                data_valid <= 1'b0;
            end

            if (!enable) begin
                state    <= IDLE;
                baud_cnt <= '0;
                bit_idx  <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (rxd_s == UART_START_LVL) begin
                            state    <= START;
                            baud_cnt <= '0;
                        end
                    end

                    START: begin
                        if (baud_cnt == START_DECIDE) begin
                            baud_cnt <= '0;
                            bit_idx  <= '0;
                            // A start bit that is gone by mid-bit was a glitch
                            state    <= (sample_bit == UART_START_LVL) ? DATA : IDLE;
                        end else begin
                            baud_cnt <= baud_cnt + 1'b1;
                        end
                    end

                    DATA: begin
                        if (baud_cnt == BIT_LAST) begin
                            baud_cnt       <= '0;
                            shreg[bit_idx] <= sample_bit;
                            if (bit_idx == IDX_LAST) begin
                                state <= STOP;
                            end else begin
                                bit_idx <= bit_idx + 1'b1;
                            end
                        end else begin
                            baud_cnt <= baud_cnt + 1'b1;
                        end
                    end

                    STOP: begin
                        if (baud_cnt == BIT_LAST) begin
                            baud_cnt <= '0;
                            bit_idx  <= '0;
                            if (sample_bit == UART_IDLE_LVL) begin
                                state <= IDLE;
                                // Full buffer not drained this cycle: keep the old byte
                                if (data_valid && !data_ready) begin
                                    overrun_err <= 1'b1;
                                end else begin
                                    data_out   <= shreg;
                                    data_valid <= 1'b1;
                                end
                            end else begin
                                frame_err <= 1'b1;
                                state     <= WAIT_HI;
                            end
                        end else begin
                            baud_cnt <= baud_cnt + 1'b1;
                        end
                    end

                    WAIT_HI: begin
                        // Hold off until the break ends so it is not read as a start bit
                        if (rxd_s == UART_IDLE_LVL) begin
                            state <= IDLE;
                        end
                    end

                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule : uart_rx_frame
`default_nettype wire

// File: tb/tb_uart_rx_frame.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_uart_rx_frame
//  Brief    : Self-checking bench for uart_rx_frame (CLKS_PER_BIT = 16).
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_rx_frame;

    localparam int CPB = 16;

    logic       sys_clock = 1'b0;
    logic       reset;
    logic       enable;
    logic       rxd;
    logic       data_ready;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_err;
    logic       overrun_err;
    logic       busy;

    int checks  = 0;
    int errors  = 0;
    int ferr_cnt = 0;
    int ovr_cnt  = 0;

    logic [7:0] sb_q[$];
    logic [7:0] sb_exp;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       exp_busy;
        logic       exp_valid;
        int         exp_ferr;
    } vec_t;

    vec_t vecs[6];

    always #5 sys_clock = ~sys_clock;

    uart_rx_frame #(
        .CLKS_PER_BIT (CPB),
        .DATA_BITS    (8)
    ) dut (
        .sys_clock   (sys_clock),
        .reset       (reset),
        .enable      (enable),
        .rxd         (rxd),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .data_ready  (data_ready),
        .frame_err   (frame_err),
        .overrun_err (overrun_err),
        .busy        (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge sys_clock);
            #1;
        end
    endtask

    task automatic send_bit(input logic v);
        rxd = v;
        tick(CPB);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(stop);
    endtask

    task automatic accept();
        data_ready = 1'b1;
        tick(1);
        data_ready = 1'b0;
        tick(2);
    endtask

    // Pulse counters and scoreboard pop on every accepted byte
    always @(negedge sys_clock) begin
        if (reset === 1'b0) begin
            if (frame_err === 1'b1) ferr_cnt++;
            if (overrun_err === 1'b1) ovr_cnt++;
            if (data_valid === 1'b1 && data_ready === 1'b1) begin
                if (sb_q.size() == 0) begin
                    check("sb_unexpected_byte", {24'd0, data_out}, 32'hFFFF_FFFF);
                end else begin
                    sb_exp = sb_q.pop_front();
                    check("sb_data", {24'd0, data_out}, {24'd0, sb_exp});
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        int f0;
        int o0;

        vecs[0] = '{8'hA5, 1'b1, 1'b0, 1'b1, 0};
        vecs[1] = '{8'h3C, 1'b0, 1'b1, 1'b0, 1};
        vecs[2] = '{8'h00, 1'b1, 1'b0, 1'b1, 0};
        vecs[3] = '{8'hFF, 1'b1, 1'b0, 1'b1, 0};
        vecs[4] = '{8'h80, 1'b0, 1'b1, 1'b0, 1};
        vecs[5] = '{8'h01, 1'b1, 1'b0, 1'b1, 0};

        reset      = 1'b1;
        enable     = 1'b1;
        rxd        = 1'b1;
        data_ready = 1'b0;
        tick(3);
        check("rst_data_out", {24'd0, data_out}, 32'd0);
        check("rst_valid", {31'd0, data_valid}, 32'd0);
        check("rst_ferr", {31'd0, frame_err}, 32'd0);
        check("rst_ovr", {31'd0, overrun_err}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        tick(5);

        // Table of single frames, each received and then drained
        for (int i = 0; i < 6; i++) begin
            f0 = ferr_cnt;
            if (vecs[i].stop) sb_q.push_back(vecs[i].data);
            send_frame(vecs[i].data, vecs[i].stop);
            check("vec_busy_end", {31'd0, busy}, {31'd0, vecs[i].exp_busy});
            if (!vecs[i].stop) begin
                tick(20);
                check("vec_busy_break", {31'd0, busy}, 32'd1);
            end
            rxd = 1'b1;
            tick(6);
            check("vec_busy_idle", {31'd0, busy}, 32'd0);
            check("vec_valid", {31'd0, data_valid}, {31'd0, vecs[i].exp_valid});
            check("vec_ferr_pulses", ferr_cnt - f0, vecs[i].exp_ferr);
            if (vecs[i].exp_valid) check("vec_data_out", {24'd0, data_out}, {24'd0, vecs[i].data});
            accept();
            check("vec_valid_cleared", {31'd0, data_valid}, 32'd0);
        end

        // Overrun: second frame commits while the first is still held
        o0 = ovr_cnt;
        sb_q.push_back(8'h11);
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        tick(4);
        check("ovr_pulses", ovr_cnt - o0, 32'd1);
        check("ovr_kept_data", {24'd0, data_out}, 32'h11);
        check("ovr_valid", {31'd0, data_valid}, 32'd1);
        accept();
        check("ovr_valid_cleared", {31'd0, data_valid}, 32'd0);

        // Start glitch shorter than half a bit
        f0 = ferr_cnt;
        rxd = 1'b0;
        tick(4);
        rxd = 1'b1;
        tick(10);
        check("glitch_busy", {31'd0, busy}, 32'd0);
        check("glitch_valid", {31'd0, data_valid}, 32'd0);
        check("glitch_ferr", ferr_cnt - f0, 32'd0);

        // enable dropped in the middle of data bit 3, frame discarded
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        rxd = 1'b0;
        tick(8);
        enable = 1'b0;
        tick(2);
        check("dis_busy", {31'd0, busy}, 32'd0);
        tick(6);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b1);
        enable = 1'b1;
        tick(4);
        check("dis_no_valid", {31'd0, data_valid}, 32'd0);
        sb_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1);
        tick(4);
        check("en_valid", {31'd0, data_valid}, 32'd1);
        check("en_data", {24'd0, data_out}, 32'h5A);
        accept();

        // Reset in the middle of a frame with a byte still held
        send_frame(8'h77, 1'b1);
        tick(4);
        check("pre_rst_data", {24'd0, data_out}, 32'h77);
        send_bit(1'b0);
        send_bit(1'b1);
        check("pre_rst_busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        #1;
        check("mid_rst_data", {24'd0, data_out}, 32'd0);
        check("mid_rst_valid", {31'd0, data_valid}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_errs", {30'd0, frame_err, overrun_err}, 32'd0);
        rxd = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(20);

`ifdef UART_RX_MAJORITY_EN
        // One-cycle low spikes near every data mid-bit are out-voted
        sb_q.push_back(8'hFF);
        send_bit(1'b0);
        for (int b = 0; b < 8; b++) begin
            rxd = 1'b1;
            tick(7);
            rxd = 1'b0;
            tick(1);
            rxd = 1'b1;
            tick(8);
        end
        send_bit(1'b1);
        tick(4);
        check("maj_valid", {31'd0, data_valid}, 32'd1);
        check("maj_data", {24'd0, data_out}, 32'hFF);
        accept();
`endif

        check("sb_empty", sb_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_uart_rx_frame
`default_nettype wire
